// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: synchronises rx, qualifies the start bit at
// mid-bit, samples DATA_BITS data bits LSB-first and checks the stop bit.
// Bit timing comes from an external b_tick pulse (OVERSAMPLE ticks per bit).
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit, the PARITY
// state and the parity_err output (sense selected by PARITY_ODD).
module uart_rx_oversample #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    // Parameter sanity checks at elaboration.
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_db
        $error("DATA_BITS must be 5..8");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_chk_os
        $error("OVERSAMPLE must be even and >= 4");
    end
    if (SYNC_STAGES < 2) begin : g_chk_ss
        $error("SYNC_STAGES must be >= 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_chk_po
        $error("PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY
`endif
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_done_q, rx_done_d;
    logic                   rx_busy_q, rx_busy_d;
    logic                   frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   parity_err_q, parity_err_d;
`endif

    assign rs = sync_q[SYNC_STAGES-1];

    // Metastability synchroniser for the asynchronous rx line (idles high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            rx_busy_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            rx_busy_q   <= rx_busy_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Next-state logic: ticks are only counted in the bit-timed states.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (!rs) begin
                    state_d = S_START;
                    tick_d  = '0;
                end
            end
            S_START: begin
                if (b_tick) begin
                    if (tick_q == HALF_M1) begin
                        tick_d = '0;
                        if (!rs) begin
                            state_d = S_DATA;
                            bit_d   = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (b_tick) begin
                    if (tick_q == FULL_M1) begin
                        tick_d  = '0;
                        shift_d = {rs, shift_q[DATA_BITS-1:1]};
                        if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (b_tick) begin
                    if (tick_q == FULL_M1) begin
                        tick_d  = '0;
                        par_d   = rs;
                        state_d = S_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (b_tick) begin
                    if (tick_q == FULL_M1) begin
                        tick_d = '0;
                        if (rs) begin
                            rx_data_d = shift_q;
                            rx_done_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err_d = ((^shift_q) ^ par_q) != (PARITY_ODD != 0);
`endif
                            state_d = S_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_BRK;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_BRK: begin
                if (rs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Registered from the next state so busy tracks the state register exactly.
        rx_busy_d = (state_d != S_IDLE);
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign rx_busy   = rx_busy_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed self-checking bench for uart_rx_oversample (8N1, b_tick every
// 4 clk, 64 clk per bit). Parity scenario is built with UART_RX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_rx_oversample;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       b_tick = 1'b0;
    logic       rx     = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_chk = 0;
    int n_err = 0;

    int         done_cnt = 0;
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    int         perr_cnt = 0;
    logic [7:0] rx_log[$];

    int d0;
    int f0;
    int p0;
    int base;

    uart_rx_oversample #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .SYNC_STAGES(2),
        .PARITY_ODD (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .b_tick   (b_tick),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rx_busy  (rx_busy),
        .frame_err(frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    // One-clock b_tick pulse every 4 clocks.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            b_tick = 1'b1;
            @(negedge clk);
            b_tick = 1'b0;
        end
    end

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt = done_cnt + 1;
            rx_log.push_back(rx_data);
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (rx_done && frame_err) both_cnt = both_cnt + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err && rx_done) perr_cnt = perr_cnt + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_body(input logic [7:0] d);
        send_bit(1'b0);
        for (int unsigned i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        send_body(d);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_v);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset state.
        repeat (5) @(negedge clk);
        check("rst_data", rx_data, 8'h00);
        check("rst_done", rx_done, 1'b0);
        check("rst_busy", rx_busy, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        rst = 1'b0;
        idle(20);

        // Single 0x55 frame.
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b1);
        idle(32);
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_data", rx_data, 8'h55);
        check("t1_ferr_cnt", ferr_cnt - f0, 0);
        check("t1_busy", rx_busy, 1'b0);

        // Back-to-back frames, no idle gap.
        d0 = done_cnt; base = rx_log.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'hA5, 1'b1);
        idle(32);
        check("t2_done_cnt", done_cnt - d0, 3);
        check("t2_byte0", (rx_log.size() > base)     ? rx_log[base]     : 8'hxx, 8'h00);
        check("t2_byte1", (rx_log.size() > base + 1) ? rx_log[base + 1] : 8'hxx, 8'hFF);
        check("t2_byte2", (rx_log.size() > base + 2) ? rx_log[base + 2] : 8'hxx, 8'hA5);

        // Short low glitch (4 ticks) is rejected at mid-start.
        d0 = done_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        repeat (12) @(negedge clk);
        check("t3_busy_start", rx_busy, 1'b1);
        repeat (4) @(negedge clk);
        idle(100);
        check("t3_busy_idle", rx_busy, 1'b0);
        check("t3_done_cnt", done_cnt - d0, 0);
        check("t3_ferr_cnt", ferr_cnt - f0, 0);

        // Framing error and line break, then recovery.
        send_frame(8'h12, 1'b1);
        idle(32);
        check("t4_pre_data", rx_data, 8'h12);
        d0 = done_cnt; f0 = ferr_cnt;
        send_body(8'hA5);
`ifdef UART_RX_PARITY_EN
        send_bit(1'b0);
`endif
        rx = 1'b0;
        repeat (200) @(negedge clk);
        check("t4_ferr_cnt", ferr_cnt - f0, 1);
        check("t4_done_cnt", done_cnt - d0, 0);
        check("t4_data_kept", rx_data, 8'h12);
        check("t4_busy_brk", rx_busy, 1'b1);
        idle(10);
        check("t4_busy_rel", rx_busy, 1'b0);
        idle(20);
        d0 = done_cnt;
        send_frame(8'h3C, 1'b1);
        idle(32);
        check("t4_rec_cnt", done_cnt - d0, 1);
        check("t4_rec_data", rx_data, 8'h3C);

        // Asynchronous reset in the middle of a data bit of 0x81.
        d0 = done_cnt; f0 = ferr_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_data", rx_data, 8'h00);
        check("t5_rst_busy", rx_busy, 1'b0);
        check("t5_rst_done", rx_done, 1'b0);
        check("t5_rst_ferr", frame_err, 1'b0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(100);
        check("t5_abort_done", done_cnt - d0, 0);
        check("t5_abort_ferr", ferr_cnt - f0, 0);
        d0 = done_cnt;
        send_frame(8'h7E, 1'b1);
        idle(32);
        check("t5_next_cnt", done_cnt - d0, 1);
        check("t5_next_data", rx_data, 8'h7E);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x03 needs parity bit 0.
        d0 = done_cnt; p0 = perr_cnt;
        send_body(8'h03);
        send_bit(1'b1);
        send_bit(1'b1);
        idle(32);
        check("t6_bad_done", done_cnt - d0, 1);
        check("t6_bad_perr", perr_cnt - p0, 1);
        check("t6_bad_data", rx_data, 8'h03);
        d0 = done_cnt; p0 = perr_cnt;
        send_body(8'h03);
        send_bit(1'b0);
        send_bit(1'b1);
        idle(32);
        check("t6_good_done", done_cnt - d0, 1);
        check("t6_good_perr", perr_cnt - p0, 0);
`else
        p0 = perr_cnt;
`endif

        check("no_done_with_ferr", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
